rf_alu_seq_ctrl: RTL and testbench

RF_ALU_SEQ_CTRL -- requirements
Module: rf_alu_seq_ctrl

---
 rtl/rf_alu_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_rf_alu_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_seq_ctrl.sv
// Sequential register-file ALU controller: read two operands, compute, write back, respond.
// One operation in flight at a time; the request port is only open in IDLE.
module rf_alu_seq_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_val,
    output logic       req_rdy,
    input  logic [1:0] req_op,
    input  logic [2:0] req_src0,
    input  logic [2:0] req_src1,
    input  logic [2:0] req_dst,
    output logic [2:0] rf_read_addr,
    input  logic [7:0] rf_read_data,
    output logic       rf_write_en,
    output logic [2:0] rf_write_addr,
    output logic [7:0] rf_write_data,
    output logic       resp_val,
    input  logic       resp_rdy,
    output logic [7:0] resp_data,
    output logic [7:0] done_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WB,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] result;
    logic [1:0] op;
    logic [2:0] src0;
    logic [2:0] src1;
    logic [2:0] dst;
    logic [7:0] alu_out;

    // Modulo-256 arithmetic: carries and borrows are simply dropped.
    always_comb begin
        alu_out = opa;
        unique case (op)
            2'b00: alu_out = opa + opb;
            2'b01: alu_out = opa - opb;
            2'b10: alu_out = opa & opb;
            2'b11: alu_out = opa;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            opa        <= 8'h00;
            opb        <= 8'h00;
            result     <= 8'h00;
            op         <= 2'b00;
            src0       <= 3'd0;
            src1       <= 3'd0;
            dst        <= 3'd0;
            done_count <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_val) begin
                        op    <= req_op;
                        src0  <= req_src0;
                        src1  <= req_src1;
                        dst   <= req_dst;
                        state <= RD0;
                    end
                end
                RD0: begin
                    opa   <= rf_read_data;
                    state <= (op == 2'b11) ? WB : RD1;
                end
                RD1: begin
                    opb   <= rf_read_data;
                    state <= WB;
                end
                WB: begin
                    result <= alu_out;
                    state  <= RESP;
                end
                RESP: begin
                    if (resp_rdy) begin
                        done_count <= done_count + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register, so reset forces them at once.
    always_comb begin
        req_rdy       = (state == IDLE);
        rf_read_addr  = 3'd0;
        rf_write_en   = 1'b0;
        rf_write_addr = 3'd0;
        rf_write_data = 8'h00;
        resp_val      = 1'b0;
        resp_data     = 8'h00;
        unique case (state)
            RD0: rf_read_addr = src0;
            RD1: rf_read_addr = src1;
            WB: begin
                rf_write_en   = (dst != 3'd0);
                rf_write_addr = dst;
                rf_write_data = alu_out;
            end
            RESP: begin
                resp_val  = 1'b1;
                resp_data = result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_alu_seq_ctrl.sv
// Bench for rf_alu_seq_ctrl: register-file model, result scoreboard and cycle-accurate checks.
module tb_rf_alu_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       req_val;
    logic       req_rdy;
    logic [1:0] req_op;
    logic [2:0] req_src0;
    logic [2:0] req_src1;
    logic [2:0] req_dst;
    logic [2:0] rf_read_addr;
    logic [7:0] rf_read_data;
    logic       rf_write_en;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       resp_val;
    logic       resp_rdy;
    logic [7:0] resp_data;
    logic [7:0] done_count;

    logic [7:0] rf [8] = '{8'h00, 8'h30, 8'h25, 8'h00,
                           8'h10, 8'h20, 8'h00, 8'h00};
    logic [7:0] sb [$];
    logic [7:0] exp_done;
    logic [7:0] r3_saved;
    int         n_cmp;
    int         n_err;

    rf_alu_seq_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_op        (req_op),
        .req_src0      (req_src0),
        .req_src1      (req_src1),
        .req_dst       (req_dst),
        .rf_read_addr  (rf_read_addr),
        .rf_read_data  (rf_read_data),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .resp_val      (resp_val),
        .resp_rdy      (resp_rdy),
        .resp_data     (resp_data),
        .done_count    (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_read_data = (rf_read_addr == 3'd0) ? 8'h00 : rf[rf_read_addr];

    always @(posedge clk) begin
        if (rf_write_en && rf_write_addr != 3'd0)
            rf[rf_write_addr] <= rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd_model(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : rf[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check timing of reads/write/response, optionally stall RESP.
    task automatic run_op(input logic [1:0] op, input logic [2:0] s0,
                          input logic [2:0] s1, input logic [2:0] d,
                          input int stall);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] held;
        int         wcyc;
        int         rcyc;
        a = rd_model(s0);
        b = rd_model(s1);
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a;
        endcase
        sb.push_back(r);
        resp_rdy = (stall == 0);
        req_val  = 1'b1;
        req_op   = op;
        req_src0 = s0;
        req_src1 = s1;
        req_dst  = d;
        chk("req_rdy_idle", req_rdy, 1);
        tick();
        req_val = 1'b0;
        wcyc = 0;
        rcyc = 0;
        for (int c = 1; c <= 8 && rcyc == 0; c++) begin
            if (c == 1)
                chk("rd_addr_src0", rf_read_addr, s0);
            if (c == 2 && op != 2'b11)
                chk("rd_addr_src1", rf_read_addr, s1);
            if (rf_write_en) begin
                wcyc = c;
                chk("wr_addr", rf_write_addr, d);
                chk("wr_data", rf_write_data, r);
            end
            if (resp_val) begin
                rcyc = c;
                chk("resp_data", resp_data, sb.pop_front());
            end else begin
                tick();
            end
        end
        if (rcyc == 0 && sb.size() > 0)
            void'(sb.pop_front());
        chk("wr_cycle", wcyc, (d == 3'd0) ? 0 : ((op == 2'b11) ? 2 : 3));
        chk("resp_cycle", rcyc, (op == 2'b11) ? 3 : 4);
        held = resp_data;
        for (int k = 0; k < stall; k++) begin
            req_val  = 1'b1;
            req_op   = 2'b00;
            req_src0 = 3'd7;
            req_src1 = 3'd7;
            req_dst  = 3'd7;
            tick();
            chk("stall_val", resp_val, 1);
            chk("stall_data", resp_data, held);
            chk("stall_rdy", req_rdy, 0);
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        tick();
        exp_done = exp_done + 8'd1;
        chk("done_count", done_count, exp_done);
        chk("back_idle", req_rdy, 1);
        chk("resp_val_low", resp_val, 0);
        chk("resp_data_low", resp_data, 0);
        if (stall > 0) begin
            tick();
            chk("no_latch_rd", rf_read_addr, 0);
            chk("no_latch_rdy", req_rdy, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_done = 8'h00;
        reset_n  = 1'b0;
        req_val  = 1'b0;
        req_op   = 2'b00;
        req_src0 = 3'd0;
        req_src1 = 3'd0;
        req_dst  = 3'd0;
        resp_rdy = 1'b1;
        #1;
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_wr_en", rf_write_en, 0);
        chk("rst_rd_addr", rf_read_addr, 0);
        chk("rst_done", done_count, 8'h00);
        tick();
        reset_n = 1'b1;

        run_op(2'b00, 3'd1, 3'd2, 3'd3, 0);
        chk("r3_add", rf[3], 8'h55);
        run_op(2'b01, 3'd4, 3'd5, 3'd6, 0);
        chk("r6_sub", rf[6], 8'hF0);
        run_op(2'b11, 3'd1, 3'd0, 3'd0, 0);
        run_op(2'b10, 3'd3, 3'd6, 3'd7, 0);
        chk("r7_and", rf[7], 8'h50);
        run_op(2'b01, 3'd2, 3'd2, 3'd4, 0);
        chk("r4_same_src", rf[4], 8'h00);
        run_op(2'b00, 3'd1, 3'd2, 3'd5, 3);
        run_op(2'b00, 3'd1, 3'd1, 3'd1, 0);
        chk("r1_src_dst", rf[1], 8'h60);
        run_op(2'b11, 3'd0, 3'd0, 3'd2, 0);
        chk("r2_copy_r0", rf[2], 8'h00);

        while (exp_done != 8'hFF) begin
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);
        end
        run_op(2'b00, 3'd1, 3'd2, 3'd0, 0);
        chk("done_wrap", done_count, 8'h00);

        rf[1] = 8'h30;
        rf[2] = 8'h25;
        r3_saved = 8'hA5;
        rf[3] = r3_saved;
        #1;
        req_val  = 1'b1;
        req_op   = 2'b00;
        req_src0 = 3'd1;
        req_src1 = 3'd2;
        req_dst  = 3'd3;
        tick();
        req_val = 1'b0;
        tick();
        chk("abort_in_rd1", rf_read_addr, 2);
        reset_n = 1'b0;
        #1;
        chk("abort_rdy", req_rdy, 1);
        chk("abort_wr_en", rf_write_en, 0);
        chk("abort_resp", resp_val, 0);
        chk("abort_done", done_count, 0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_wr", rf_write_en, 0);
            chk("post_rst_resp", resp_val, 0);
        end
        chk("post_rst_rdy", req_rdy, 1);
        chk("post_rst_done", done_count, 0);
        chk("r3_kept", rf[3], r3_saved);
        exp_done = 8'h00;
        run_op(2'b01, 3'd1, 3'd2, 3'd3, 0);
        chk("r3_after", rf[3], 8'h0B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
